// File: rtl/reqwalker_arbiter_if.sv
// Bus bundle for the two-master reqwalker arbiter: both master ports and the
// shared walker slave port, named from the arbiter's point of view.
interface reqwalker_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 1
) ();

    // Master A
    logic          i_a_cyc;
    logic          i_a_stb;
    logic          i_a_we;
    logic [AW-1:0] i_a_addr;
    logic [DW-1:0] i_a_data;
    logic          o_a_stall;
    logic          o_a_ack;
    logic [DW-1:0] o_a_data;

    // Master B
    logic          i_b_cyc;
    logic          i_b_stb;
    logic          i_b_we;
    logic [AW-1:0] i_b_addr;
    logic [DW-1:0] i_b_data;
    logic          o_b_stall;
    logic          o_b_ack;
    logic [DW-1:0] o_b_data;

    // Walker slave
    logic          o_cyc;
    logic          o_stb;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          i_stall;
    logic          i_ack;
    logic [DW-1:0] i_data;

    // Arbiter side.
    modport slave (
        input  i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        output o_a_stall, o_a_ack, o_a_data,
        input  i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        output o_b_stall, o_b_ack, o_b_data,
        output o_cyc, o_stb, o_we, o_addr, o_data,
        input  i_stall, i_ack, i_data
    );

    // Environment side: the two masters and the walker.
    modport master (
        output i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        input  o_a_stall, o_a_ack, o_a_data,
        output i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        input  o_b_stall, o_b_ack, o_b_data,
        input  o_cyc, o_stb, o_we, o_addr, o_data,
        output i_stall, i_ack, i_data
    );

endinterface

// File: rtl/reqwalker_arbiter.sv
// Round-robin two-master pipelined Wishbone arbiter in front of a reqwalker slave.
// The grant only moves once every request issued by the current owner is acked.
module reqwalker_arbiter #(
    parameter int DW               = 32,
    parameter int AW               = 1,
    parameter int LGOUT            = 4,
    parameter bit OPT_ZERO_ON_IDLE = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    reqwalker_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } owner_e;

    state_e            state_q, state_d;
    owner_e            last_q, last_d;
    logic [LGOUT-1:0]  outstanding_q, outstanding_d;

    logic              granted_a;
    logic              granted_b;
    logic              drained;
    logic              full;
    logic              accept;
    logic              retire;

    logic              mux_cyc;
    logic              mux_stb;
    logic              mux_we;
    logic [AW-1:0]     mux_addr;
    logic [DW-1:0]     mux_data;
    logic [DW-1:0]     idle_data;

    assign granted_a = (state_q == GRANT_A);
    assign granted_b = (state_q == GRANT_B);
    assign drained   = (outstanding_q == '0);
    assign full      = &outstanding_q;

    // ------------------------------------------------------------------
    // Grant state machine
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_a_cyc && bus.i_b_cyc) begin
                    state_d = (last_q == LAST_B) ? GRANT_A : GRANT_B;
                end else if (bus.i_a_cyc) begin
                    state_d = GRANT_A;
                end else if (bus.i_b_cyc) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!bus.i_a_cyc && drained) begin
                    last_d  = LAST_A;
                    state_d = bus.i_b_cyc ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (!bus.i_b_cyc && drained) begin
                    last_d  = LAST_B;
                    state_d = bus.i_a_cyc ? GRANT_A : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outstanding-request counter
    // ------------------------------------------------------------------
    // An ack seen with nothing outstanding (e.g. just after reset) is ignored
    // so the counter never wraps below zero.
    assign accept = mux_stb && !bus.i_stall;
    assign retire = bus.i_ack && !drained;

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({accept, retire})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            last_q        <= LAST_B;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            outstanding_q <= outstanding_d;
        end
    end

    // ------------------------------------------------------------------
    // Request forwarding to the walker
    // ------------------------------------------------------------------
    // stb is also held off when the counter is full: the master already sees
    // stall then, and the walker must not accept a request we cannot count.
    always_comb begin
        mux_cyc  = 1'b0;
        mux_stb  = 1'b0;
        mux_we   = 1'b0;
        mux_addr = '0;
        mux_data = '0;
        unique case (state_q)
            GRANT_A: begin
                mux_cyc  = bus.i_a_cyc;
                mux_stb  = bus.i_a_cyc && bus.i_a_stb && !full;
                mux_we   = bus.i_a_we;
                mux_addr = bus.i_a_addr;
                mux_data = bus.i_a_data;
            end
            GRANT_B: begin
                mux_cyc  = bus.i_b_cyc;
                mux_stb  = bus.i_b_cyc && bus.i_b_stb && !full;
                mux_we   = bus.i_b_we;
                mux_addr = bus.i_b_addr;
                mux_data = bus.i_b_data;
            end
            default: begin
                mux_cyc = 1'b0;
            end
        endcase
    end

    assign bus.o_cyc  = mux_cyc;
    assign bus.o_stb  = mux_stb;
    assign bus.o_we   = mux_we;
    assign bus.o_addr = mux_addr;
    assign bus.o_data = mux_data;

    // ------------------------------------------------------------------
    // Responses back to the masters
    // ------------------------------------------------------------------
    // Acks after the owner dropped cyc reach nobody; they only drain the counter.
    assign bus.o_a_stall = !granted_a || bus.i_stall || full;
    assign bus.o_b_stall = !granted_b || bus.i_stall || full;

    assign bus.o_a_ack   = bus.i_ack && granted_a && bus.i_a_cyc;
    assign bus.o_b_ack   = bus.i_ack && granted_b && bus.i_b_cyc;

    assign idle_data     = OPT_ZERO_ON_IDLE ? '0 : bus.i_data;
    assign bus.o_a_data  = granted_a ? bus.i_data : idle_data;
    assign bus.o_b_data  = granted_b ? bus.i_data : idle_data;

endmodule

// File: tb/tb_reqwalker_arbiter.sv
// Directed bench for reqwalker_arbiter: a small walker model acks one cycle
// after each accepted request; each scenario checks outputs by hand.
module tb_reqwalker_arbiter;

    localparam int DW = 32;
    localparam int AW = 1;

    logic i_clk;
    logic i_reset;

    int checks = 0;
    int errors = 0;

    bit   auto_ack;
    logic force_ack;
    logic walk_ack_q;

    reqwalker_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    reqwalker_arbiter #(
        .DW(DW), .AW(AW), .LGOUT(4), .OPT_ZERO_ON_IDLE(1'b1)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Walker slave model: acks one cycle after it accepts a request.
    always @(posedge i_clk) begin
        walk_ack_q <= auto_ack && bus.o_cyc && bus.o_stb && !bus.i_stall;
    end
    assign bus.i_ack = walk_ack_q | force_ack;

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_a_cyc = 1'b0; bus.i_a_stb = 1'b0; bus.i_a_we = 1'b0;
        bus.i_a_addr = '0;  bus.i_a_data = '0;
        bus.i_b_cyc = 1'b0; bus.i_b_stb = 1'b0; bus.i_b_we = 1'b0;
        bus.i_b_addr = '0;  bus.i_b_data = '0;
        bus.i_stall = 1'b0; bus.i_data = '0;
        force_ack = 1'b0;
        auto_ack  = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_reset = 1'b1;
        next_cycle();
        next_cycle();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.o_cyc !== 1'b0) begin errors++; $display("FAIL reset_o_cyc: got %b want 0", bus.o_cyc); end
        checks++; if (bus.o_stb !== 1'b0) begin errors++; $display("FAIL reset_o_stb: got %b want 0", bus.o_stb); end
        checks++; if (bus.o_a_stall !== 1'b1) begin errors++; $display("FAIL reset_a_stall: got %b want 1", bus.o_a_stall); end
        checks++; if (bus.o_b_stall !== 1'b1) begin errors++; $display("FAIL reset_b_stall: got %b want 1", bus.o_b_stall); end
        checks++; if ({bus.o_a_ack, bus.o_b_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {bus.o_a_ack, bus.o_b_ack}); end
    endtask

    task automatic test_single_write();
        do_reset();
        // cycle 0: A requests from IDLE
        bus.i_a_cyc = 1'b1; bus.i_a_stb = 1'b1; bus.i_a_we = 1'b1; bus.i_a_data = 32'h1;
        #1;
        checks++; if (bus.o_a_stall !== 1'b1) begin errors++; $display("FAIL write_c0_a_stall: got %b want 1", bus.o_a_stall); end
        checks++; if (bus.o_stb !== 1'b0) begin errors++; $display("FAIL write_c0_o_stb: got %b want 0", bus.o_stb); end
        // cycle 1: granted, request forwarded
        next_cycle(); #1;
        checks++; if (bus.o_stb !== 1'b1) begin errors++; $display("FAIL write_c1_o_stb: got %b want 1", bus.o_stb); end
        checks++; if (bus.o_a_stall !== 1'b0) begin errors++; $display("FAIL write_c1_a_stall: got %b want 0", bus.o_a_stall); end
        checks++; if ({bus.o_we, bus.o_data} !== {1'b1, 32'h1}) begin errors++; $display("FAIL write_c1_we_data: got %b/%h want 1/00000001", bus.o_we, bus.o_data); end
        // cycle 2: ack returns to A only
        next_cycle(); bus.i_a_stb = 1'b0; #1;
        checks++; if (bus.o_a_ack !== 1'b1) begin errors++; $display("FAIL write_c2_a_ack: got %b want 1", bus.o_a_ack); end
        checks++; if (bus.o_b_ack !== 1'b0) begin errors++; $display("FAIL write_c2_b_ack: got %b want 0", bus.o_b_ack); end
        // cycle 3: release; cycle 4 back in IDLE
        next_cycle(); bus.i_a_cyc = 1'b0; #1;
        checks++; if (bus.o_a_ack !== 1'b0) begin errors++; $display("FAIL write_c3_a_ack: got %b want 0", bus.o_a_ack); end
        next_cycle(); #1;
        checks++; if (bus.o_a_stall !== 1'b1) begin errors++; $display("FAIL write_c4_a_stall: got %b want 1", bus.o_a_stall); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        // cycle 0: tie from IDLE with last = B
        bus.i_a_cyc = 1'b1; bus.i_a_stb = 1'b1;
        bus.i_b_cyc = 1'b1; bus.i_b_stb = 1'b1;
        next_cycle(); #1;
        checks++; if ({bus.o_a_stall, bus.o_b_stall} !== 2'b01) begin errors++; $display("FAIL tie1_stalls: got %b want 01", {bus.o_a_stall, bus.o_b_stall}); end
        next_cycle(); bus.i_a_stb = 1'b0; #1;
        checks++; if (bus.o_a_ack !== 1'b1) begin errors++; $display("FAIL tie1_a_ack: got %b want 1", bus.o_a_ack); end
        // A drops cyc with nothing outstanding: B granted on the next edge
        next_cycle(); bus.i_a_cyc = 1'b0; #1;
        checks++; if (bus.o_b_stall !== 1'b1) begin errors++; $display("FAIL handover_b_stall_before: got %b want 1", bus.o_b_stall); end
        next_cycle(); #1;
        checks++; if (bus.o_b_stall !== 1'b0) begin errors++; $display("FAIL handover_b_stall_after: got %b want 0", bus.o_b_stall); end
        checks++; if (bus.o_stb !== 1'b1) begin errors++; $display("FAIL handover_o_stb: got %b want 1", bus.o_stb); end
        next_cycle(); bus.i_b_stb = 1'b0; #1;
        checks++; if (bus.o_b_ack !== 1'b1) begin errors++; $display("FAIL handover_b_ack: got %b want 1", bus.o_b_ack); end
        // B releases into IDLE, leaving last = B
        next_cycle(); bus.i_b_cyc = 1'b0;
        next_cycle();
        // second tie: A must win again since B was last
        bus.i_a_cyc = 1'b1; bus.i_a_stb = 1'b1;
        bus.i_b_cyc = 1'b1; bus.i_b_stb = 1'b1;
        next_cycle(); #1;
        checks++; if ({bus.o_a_stall, bus.o_b_stall} !== 2'b01) begin errors++; $display("FAIL tie2_stalls: got %b want 01", {bus.o_a_stall, bus.o_b_stall}); end
    endtask

    task automatic test_drain();
        do_reset();
        bus.i_a_cyc = 1'b1; bus.i_a_stb = 1'b1;
        bus.i_b_cyc = 1'b1; bus.i_b_stb = 1'b1;
        // cycle 1: A granted and accepted
        next_cycle(); #1;
        checks++; if (bus.o_stb !== 1'b1) begin errors++; $display("FAIL drain_c1_o_stb: got %b want 1", bus.o_stb); end
        // cycle 2: A drops cyc while its ack arrives; ack is absorbed
        next_cycle(); bus.i_a_cyc = 1'b0; bus.i_a_stb = 1'b0; #1;
        checks++; if ({bus.o_a_ack, bus.o_b_ack} !== 2'b00) begin errors++; $display("FAIL drain_absorb_acks: got %b want 00", {bus.o_a_ack, bus.o_b_ack}); end
        checks++; if (bus.o_b_stall !== 1'b1) begin errors++; $display("FAIL drain_c2_b_stall: got %b want 1", bus.o_b_stall); end
        // cycle 3: counter drained this edge, grant still with A
        next_cycle(); #1;
        checks++; if (bus.o_b_stall !== 1'b1) begin errors++; $display("FAIL drain_c3_b_stall: got %b want 1", bus.o_b_stall); end
        checks++; if (bus.o_cyc !== 1'b0) begin errors++; $display("FAIL drain_c3_o_cyc: got %b want 0", bus.o_cyc); end
        // cycle 4: B owns the bus
        next_cycle(); #1;
        checks++; if ({bus.o_b_stall, bus.o_stb} !== 2'b01) begin errors++; $display("FAIL drain_c4_b_grant: got stall/stb %b want 01", {bus.o_b_stall, bus.o_stb}); end
        next_cycle(); bus.i_b_stb = 1'b0; #1;
        checks++; if (bus.o_b_ack !== 1'b1) begin errors++; $display("FAIL drain_c5_b_ack: got %b want 1", bus.o_b_ack); end
    endtask

    task automatic test_busy_walker();
        int acks;
        acks = 0;
        do_reset();
        bus.i_a_cyc = 1'b1; bus.i_a_stb = 1'b1; bus.i_a_we = 1'b1; bus.i_a_data = 32'h2;
        bus.i_b_cyc = 1'b1; bus.i_b_stb = 1'b1;
        next_cycle();                     // cycle 1: first write accepted
        next_cycle();                     // cycle 2: second write, walker busy
        bus.i_a_data = 32'h3; bus.i_stall = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) next_cycle();
            #1;
            if (bus.o_a_ack) acks++;
            checks++; if (bus.o_a_stall !== 1'b1) begin errors++; $display("FAIL busy_a_stall[%0d]: got %b want 1", i, bus.o_a_stall); end
            checks++; if (bus.o_b_stall !== 1'b1) begin errors++; $display("FAIL busy_b_stall[%0d]: got %b want 1", i, bus.o_b_stall); end
        end
        next_cycle(); bus.i_stall = 1'b0; #1;   // cycle 13: accepted
        if (bus.o_a_ack) acks++;
        checks++; if (bus.o_a_stall !== 1'b0) begin errors++; $display("FAIL busy_release_a_stall: got %b want 0", bus.o_a_stall); end
        next_cycle(); bus.i_a_stb = 1'b0; #1;   // cycle 14: second ack
        if (bus.o_a_ack) acks++;
        checks++; if (bus.o_a_ack !== 1'b1) begin errors++; $display("FAIL busy_second_ack: got %b want 1", bus.o_a_ack); end
        next_cycle(); bus.i_a_cyc = 1'b0; #1;
        if (bus.o_a_ack) acks++;
        checks++; if (acks !== 2) begin errors++; $display("FAIL busy_ack_count: got %0d want 2", acks); end
    endtask

    task automatic test_read_isolation();
        do_reset();
        bus.i_data  = 32'h5;
        bus.i_a_cyc = 1'b1; bus.i_a_stb = 1'b1; bus.i_a_we = 1'b0;
        #1;
        checks++; if (bus.o_a_data !== 32'h0) begin errors++; $display("FAIL read_c0_a_data: got %h want 00000000", bus.o_a_data); end
        next_cycle(); #1;
        checks++; if (bus.o_a_data !== 32'h5) begin errors++; $display("FAIL read_c1_a_data: got %h want 00000005", bus.o_a_data); end
        checks++; if (bus.o_b_data !== 32'h0) begin errors++; $display("FAIL read_c1_b_data: got %h want 00000000", bus.o_b_data); end
        next_cycle(); bus.i_a_stb = 1'b0; #1;
        checks++; if ({bus.o_a_ack, bus.o_a_data} !== {1'b1, 32'h5}) begin errors++; $display("FAIL read_c2_ack_data: got %b/%h want 1/00000005", bus.o_a_ack, bus.o_a_data); end
        next_cycle(); bus.i_a_cyc = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_b_cyc = 1'b1; bus.i_b_stb = 1'b1;
        next_cycle();                     // cycle 1: GRANT_B, request accepted
        auto_ack = 1'b0;                  // hold the walker's ack back
        #1;
        checks++; if (bus.o_stb !== 1'b1) begin errors++; $display("FAIL rstmid_c1_o_stb: got %b want 1", bus.o_stb); end
        next_cycle();                     // cycle 2: one outstanding, reset asserted
        bus.i_b_stb = 1'b0; i_reset = 1'b1;
        next_cycle();                     // cycle 3: late ack must be dropped
        i_reset = 1'b0; force_ack = 1'b1; #1;
        checks++; if (bus.o_b_ack !== 1'b0) begin errors++; $display("FAIL rstmid_b_ack: got %b want 0", bus.o_b_ack); end
        checks++; if ({bus.o_cyc, bus.o_stb} !== 2'b00) begin errors++; $display("FAIL rstmid_o_cyc_stb: got %b want 00", {bus.o_cyc, bus.o_stb}); end
        checks++; if (bus.o_b_stall !== 1'b1) begin errors++; $display("FAIL rstmid_b_stall_idle: got %b want 1", bus.o_b_stall); end
        next_cycle();                     // cycle 4: B regranted with an empty counter
        force_ack = 1'b0; auto_ack = 1'b1; #1;
        checks++; if (bus.o_b_stall !== 1'b0) begin errors++; $display("FAIL rstmid_regrant_b_stall: got %b want 0", bus.o_b_stall); end
        checks++; if (bus.o_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_regrant_o_cyc: got %b want 1", bus.o_cyc); end
        next_cycle(); bus.i_b_cyc = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_drain();
        test_busy_walker();
        test_read_isolation();
        test_reset_mid();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
